// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-memory path.
// Load/store funct3 codes, responder FSM states and byte-lane helpers.
package riscv_pkg;

    localparam int XLEN = 32;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        RESP  = 2'd2
    } dmem_state_e;

    // Byte strobe of the access size, before positioning at the lane.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Strobe across two consecutive words: [3:0] = word W, [7:4] = word W+1.
    function automatic logic [7:0] wide_lane_mask(input logic [2:0] funct3,
                                                  input logic [1:0] lane);
        return {4'b0000, size_mask(funct3)} << lane;
    endfunction

    // Byte strobe inside the addressed word.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] lane);
        logic [7:0] m;
        m = wide_lane_mask(funct3, lane);
        return m[3:0];
    endfunction

    // Byte strobe spilling into the following word.
    function automatic logic [3:0] lane_mask_hi(input logic [2:0] funct3,
                                                input logic [1:0] lane);
        logic [7:0] m;
        m = wide_lane_mask(funct3, lane);
        return m[7:4];
    endfunction

    function automatic logic load_legal(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    function automatic logic store_legal(input logic [2:0] funct3);
        return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input logic [2:0] funct3,
                                        input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Extract the field starting at byte lane and extend it per funct3.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [31:0] f;
        f = word >> {lane, 3'b000};
        case (funct3)
            F3_LB:   return {{24{f[7]}}, f[7:0]};
            F3_LH:   return {{16{f[15]}}, f[15:0]};
            F3_LW:   return f;
            F3_LBU:  return {24'd0, f[7:0]};
            F3_LHU:  return {16'd0, f[15:0]};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: 32-bit words, four byte-write strobes,
// synchronous write and combinational read. Contents are never reset.
module dmem_ram #(
    parameter  int WORDS = 1024,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    // Byte-lane write; lanes whose strobe is low keep their old contents.
    // NOTE: the array has no reset branch -- clearing a RAM would need a per-word
    // sweep and would stop it mapping onto block memory.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's load/store channel.
// One request at a time over valid/ready, registered response with error flag.
// Optional DMEM_MISALIGN_SPLIT_EN: misaligned accesses are split over two
// consecutive words (SPLIT state); without it they return an error.
module dmem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int XLEN      = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
);

    import riscv_pkg::*;

    localparam int            AW         = $clog2(MEM_WORDS);
    localparam logic [XLEN:0] BYTE_LIMIT = (XLEN+1)'(MEM_WORDS) << 2;

    dmem_state_e     r_state;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_accept;
    logic [1:0]      w_lane;
    logic [AW-1:0]   w_word;
    logic            w_legal;
    logic            w_misal;
    logic            w_oor;
    logic            w_err;

    logic [AW-1:0]   w_ram_addr;
    logic            w_ram_we;
    logic [3:0]      w_ram_be;
    logic [31:0]     w_ram_wdata;
    logic [31:0]     w_ram_rdata;

    // Request decode
    assign req_ready_o = (r_state == IDLE) || ((r_state == RESP) && rsp_ready_i);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_lane      = req_addr_i[1:0];
    assign w_word      = req_addr_i[AW+1:2];
    assign w_legal     = req_we_i ? store_legal(req_funct3_i) : load_legal(req_funct3_i);
    assign w_misal     = misaligned(req_funct3_i, w_lane);
    assign w_oor       = {1'b0, req_addr_i} >= BYTE_LIMIT;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic            w_hi_oor;
    logic            w_split;
    logic [AW-1:0]   r_word_hi;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [3:0]      r_hi_be;
    logic [31:0]     r_hi_wdata;
    logic [31:0]     r_lo_word;

    // The second half lives in word W+1; that word must exist too.
    assign w_hi_oor = (32'(w_word) + 32'd1) >= 32'(MEM_WORDS);
    assign w_split  = w_legal && !w_oor && w_misal && !w_hi_oor;
    assign w_err    = !w_legal || w_oor || (w_misal && w_hi_oor);
`else
    assign w_err    = !w_legal || w_oor || w_misal;
`endif

    // RAM port mux: the request word at accept, word W+1 during SPLIT.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_ram_addr  = w_word;
        w_ram_we    = w_accept && req_we_i && !w_err;
        w_ram_be    = lane_mask(req_funct3_i, w_lane);
        w_ram_wdata = req_wdata_i << {w_lane, 3'b000};
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (r_state == SPLIT) begin
            w_ram_addr  = r_word_hi;
            w_ram_we    = r_we;
            w_ram_be    = r_hi_be;
            w_ram_wdata = r_hi_wdata;
        end
`endif
    end

    dmem_ram #(
        .WORDS (MEM_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Responder FSM with registered response outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            r_word_hi   <= '0;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_hi_be     <= '0;
            r_hi_wdata  <= '0;
            r_lo_word   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                        if (w_split) begin
                            // First half is done now; remember what word W+1 needs.
                            r_state     <= SPLIT;
                            r_rsp_valid <= 1'b0;
                            r_word_hi   <= w_word + AW'(1);
                            r_we        <= req_we_i;
                            r_funct3    <= req_funct3_i;
                            r_lane      <= w_lane;
                            r_hi_be     <= lane_mask_hi(req_funct3_i, w_lane);
                            r_hi_wdata  <= req_wdata_i >> (6'd32 - {1'b0, w_lane, 3'b000});
                            r_lo_word   <= w_ram_rdata;
                        end else
`endif
                        begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= (w_err || req_we_i) ? '0
                                         : load_extend(req_funct3_i, w_ram_rdata, w_lane);
                        end
                    end else if ((r_state == RESP) && rsp_ready_i) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                SPLIT: begin
                    // Word W+1 is on the RAM port; stitch both words little-endian.
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? '0
                                 : load_extend(r_funct3,
                                               32'({w_ram_rdata, r_lo_word} >> {r_lane, 3'b000}),
                                               2'b00);
                end
`endif
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_dmem_responder;

    localparam int MEM_WORDS = 1024;
    localparam longint LIMIT = longint'(MEM_WORDS) * 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mem_b [int];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;

    function automatic void predict(input logic we, input logic [31:0] addr,
                                    input logic [2:0] f3, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic err,
                                    output int lat);
        int     size;
        bit     legal;
        bit     mis;
        longint last;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (addr % size) != 0;
        last  = longint'(addr) + size - 1;
        err   = !legal || (last >= LIMIT) || (mis && !SPLIT_EN);
        lat   = (!err && mis) ? 2 : 1;
        rd    = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_b[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) begin
                    v = v | (32'(mem_b.exists(int'(addr) + i) ? mem_b[int'(addr) + i] : 8'hxx) << (8*i));
                end
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endfunction

    // Cycle-by-cycle comparison against the model (inputs settle at posedge+1).
    always @(negedge clk_i) begin
        logic exp_valid;
        logic exp_ready;
        exp_t e;
        cyc++;
        if (rst_i) begin
            q.delete();
        end else begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
            exp_ready = (q.size() == 0) ? 1'b1 : (exp_valid ? rsp_ready_i : 1'b0);
            check("mon_req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("mon_rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
            if (exp_valid && rsp_valid_o) begin
                check("mon_rsp_rdata", rsp_rdata_o, q[0].rd);
                check("mon_rsp_err", 32'(rsp_err_o), 32'(q[0].err));
                if (rsp_ready_i) void'(q.pop_front());
            end
            if (req_valid_i && req_ready_o) begin
                predict(req_we_i, req_addr_i, req_funct3_i, req_wdata_i, e.rd, e.err, e.lat);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd);
        bit done;
        done = 0;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_funct3_i = f3;
        req_wdata_i  = wd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_i);
            done = req_ready_o;
            @(posedge clk_i);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic err, output int lat);
        bit done;
        done = 0;
        rd = 'x; err = 1'bx; lat = 0;
        for (int i = 1; i <= 50 && !done; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) begin
                rd = rsp_rdata_o; err = rsp_err_o; lat = i; done = 1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        err;
        int          lat;
        send(we, addr, f3, wd);
        wait_rsp(rd, err, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        if (exp_lat != 0) check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        logic [31:0] w10;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rsp_rdata", rsp_rdata_o, 32'd0);
        check("reset_rsp_err", 32'(rsp_err_o), 32'd0);
        check("reset_req_ready", 32'(req_ready_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // 1: word store and load, latency 1
        txn("t1_sw", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        txn("t1_lw", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 1);

        // 2: byte store, signed/unsigned sub-word loads
        txn("t2_sb",  1'b1, 32'h13, 3'b000, 32'h00000080, 32'h0, 1'b0, 1);
        txn("t2_lb",  1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        txn("t2_lbu", 1'b0, 32'h13, 3'b100, 32'h0, 32'h00000080, 1'b0, 0);
        txn("t2_lw",  1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0, 0);
        txn("t2_lh",  1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFF80AD, 1'b0, 0);

        // 3: response back-pressure, then accept on the releasing edge
        rsp_ready_i = 1'b0;
        send(1'b0, 32'h10, 3'b010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("t3_hold_valid", 32'(rsp_valid_o), 32'd1);
            check("t3_hold_rdata", rsp_rdata_o, 32'h80ADBEEF);
            check("t3_hold_err", 32'(rsp_err_o), 32'd0);
            check("t3_hold_ready", 32'(req_ready_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        begin
            logic [31:0] rd;
            logic        err;
            int          lat;
            req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h13; req_funct3_i = 3'b100;
            rsp_ready_i = 1'b1;
            @(negedge clk_i);
            check("t3_same_edge_ready", 32'(req_ready_o), 32'd1);
            @(posedge clk_i);
            #1;
            req_valid_i = 1'b0;
            wait_rsp(rd, err, lat);
            check("t3_b2b_rdata", rd, 32'h00000080);
            check("t3_b2b_lat", 32'(lat), 32'd1);
        end

        // 4: misaligned accesses across words 0x10/0x14
        txn("t4_sw14", 1'b1, 32'h14, 3'b010, 32'h11223344, 32'h0, 1'b0, 1);
        if (SPLIT_EN) begin
            txn("t4_lw_split", 1'b0, 32'h12, 3'b010, 32'h0, 32'h334480AD, 1'b0, 2);
            txn("t4_sh_split", 1'b1, 32'h13, 3'b001, 32'h0000A5A5, 32'h0, 1'b0, 2);
            w10 = 32'hA5ADBEEF;
            txn("t4_lw10", 1'b0, 32'h10, 3'b010, 32'h0, w10, 1'b0, 0);
            txn("t4_lw14", 1'b0, 32'h14, 3'b010, 32'h0, 32'h112233A5, 1'b0, 0);
        end else begin
            txn("t4_lw_mis", 1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1, 1);
            txn("t4_sh_mis", 1'b1, 32'h13, 3'b001, 32'h0000A5A5, 32'h0, 1'b1, 1);
            w10 = 32'h80ADBEEF;
            txn("t4_lw10", 1'b0, 32'h10, 3'b010, 32'h0, w10, 1'b0, 0);
            txn("t4_lw14", 1'b0, 32'h14, 3'b010, 32'h0, 32'h11223344, 1'b0, 0);
        end

        // 5: out-of-range, illegal funct3, split past the last word
        txn("t5_sw0",    1'b1, 32'h0, 3'b010, 32'h01020304, 32'h0, 1'b0, 0);
        txn("t5_sw_oor", 1'b1, 32'(MEM_WORDS * 4), 3'b010, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        txn("t5_lw0",    1'b0, 32'h0, 3'b010, 32'h0, 32'h01020304, 1'b0, 0);
        txn("t5_ld_f3",  1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, 1);
        txn("t5_st_f3",  1'b1, 32'h10, 3'b011, 32'h12345678, 32'h0, 1'b1, 1);
        txn("t5_sw_top", 1'b1, 32'(MEM_WORDS * 4 - 4), 3'b010, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        txn("t5_lw_edge", 1'b0, 32'(MEM_WORDS * 4 - 2), 3'b010, 32'h0, 32'h0, 1'b1, 1);
        txn("t5_sw_edge", 1'b1, 32'(MEM_WORDS * 4 - 2), 3'b010, 32'h99999999, 32'h0, 1'b1, 1);
        txn("t5_lw_top", 1'b0, 32'(MEM_WORDS * 4 - 4), 3'b010, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        txn("t5_lw0_again", 1'b0, 32'h0, 3'b010, 32'h0, 32'h01020304, 1'b0, 0);

        // 6: asynchronous reset in RESP (and in SPLIT)
        rsp_ready_i = 1'b0;
        send(1'b0, 32'h10, 3'b010, 32'h0);
        rst_i = 1'b1;
        #1;
        check("t6_resp_rst_valid", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        #1;
        check("t6_resp_rst_ready", 32'(req_ready_o), 32'd1);
        txn("t6_lw_after", 1'b0, 32'h10, 3'b010, 32'h0, w10, 1'b0, 1);
        if (SPLIT_EN) begin
            send(1'b0, 32'h12, 3'b010, 32'h0);
            rst_i = 1'b1;
            #1;
            check("t6_split_rst_valid", 32'(rsp_valid_o), 32'd0);
            @(posedge clk_i);
            #1;
            rst_i = 1'b0;
            #1;
            check("t6_split_rst_ready", 32'(req_ready_o), 32'd1);
            txn("t6_lw14_after", 1'b0, 32'h14, 3'b010, 32'h0, 32'h112233A5, 1'b0, 1);
        end

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready channel and performs byte/half/word writes using byte lanes.
- Returns loads sign- or zero-extended per RV32I funct3 on a valid/ready response channel, with an error flag.
- Sits between the core's memory stage and the data RAM array it owns.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words; byte address space is 0 .. MEM_WORDS*4-1.
- XLEN, riscv_pkg::XLEN (32): data and address width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready at clock edge.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  XLEN  byte address.
- req_funct3_i  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_wdata_i  in  XLEN  store data, low bytes used per size.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_rdata_o  out  XLEN  load result; 0 for stores and errors.
- rsp_err_o  out  1  misaligned (without split), out-of-range, or illegal funct3.

Behaviour:
- Reset values: rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, FSM=IDLE. RAM contents are not reset.
- FSM states are IDLE, SPLIT and RESP.
- req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i). It is combinational from rsp_ready_i, giving one request per cycle at full throughput.
- Aligned or erroring request:
  - Write and read happen at the accept edge.
  - Response is registered: rsp_valid_o=1 the cycle after acceptance. Latency is 1.
  - Next state is RESP.
- RESP: outputs are held stable until rsp_valid_o & rsp_ready_i.
  - Then go to IDLE, or reload with a new request if one is accepted on the same edge.
  - Back-to-back responses are allowed.
- Word index = addr[$clog2(MEM_WORDS)+1:2]; lane = addr[1:0].
- Store lanes:
  - SB writes byte lane = wdata[7:0].
  - SH writes lanes lane, lane+1 = wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Load extraction:
  - LB/LH sign-extend from bit 7/15 of the selected field.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Alignment: misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- Error cases: all of the following give err=1, no RAM write, rdata=0, latency 1.
  - addr >= MEM_WORDS*4.
  - Illegal funct3: load 3'b011/110/111; store >= 3'b011.
  - Misaligned access with the feature disabled.
- A store returns rdata=0 and err=0 on success.
- Reset during SPLIT or RESP:
  - FSM goes to IDLE and rsp_valid_o drops immediately (asynchronous).
  - A first-half split write already committed stays in RAM.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: a misaligned access is split into two word accesses.
  - Accept edge: access word W for lanes >= lane.
  - Next state is SPLIT (req_ready_o=0).
  - SPLIT edge: access word W+1 for the remaining low lanes, then assemble the result little-endian.
  - rsp_valid_o rises 2 cycles after acceptance.
  - If W+1 >= MEM_WORDS: err=1 and neither half is written. The range check covers both words at accept time.
- Undefined: SPLIT state is absent and misaligned accesses return err=1.

Decomposition:
- riscv_pkg adds:
  - typedef dmem_state_e (IDLE, SPLIT, RESP).
  - Function lane_mask(funct3, lane) returning a 4-bit byte strobe.
  - Function load_extend(funct3, word, lane).
  - Existing F3_* load/store constants are reused.
- Sub-module dmem_ram:
  - Single-port, 32-bit words, 4 byte-write strobes.
  - Synchronous write, combinational read, no reset.

Test Plan:
1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp one cycle after accept, rdata=0xDEADBEEF, err=0.
2. SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF; LH @0x12 -> 0xFFFF80AD.
3. Hold rsp_ready_i=0 for 3 cycles after a load -> rsp_valid/rdata/err stable and req_ready_o=0; raise rsp_ready_i with a new request pending -> new request accepted on that same edge.
4. Words 0x10=0x80ADBEEF, 0x14=0x11223344, then LW @0x12:
   - Without macro: err=1, rdata=0.
   - With macro: err=0, rdata=0x334480AD, latency 2.
   - SH 0xA5A5 @0x13 with macro: word 0x10=0xA5ADBEEF, word 0x14=0x112233A5.
5. SW @MEM_WORDS*4 -> err=1 and RAM unchanged; load funct3=3'b011 -> err=1, rdata=0; split LW @(MEM_WORDS*4-2) with macro -> err=1 and no write.
6. Assert rst_i mid-RESP (and mid-SPLIT with macro) -> rsp_valid_o=0 before the next edge; after release req_ready_o=1 and the next LW returns correct data.
